// File: rtl/rr_arbiter7_if.sv
// Request/grant bundle between the request sources and the 7-way round-robin arbiter.
// 'rel' is the holder's "finished" strobe; the natural name 'release' is a reserved word.
interface rr_arbiter7_if;
    logic [6:0] req;
    logic       rel;
    logic [6:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output rel,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter7.sv
// Round-robin arbiter for 7 requesters with registered one-hot grant, encoded index
// (0 = none, k+1 = requester k) and an optional maximum-hold timeout.
module rr_arbiter7 #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter7_if.slave  bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = HOLD_LAST_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [2:0]       holder_q, holder_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [6:0]       grant_q, grant_d;
    logic [2:0]       idx_q, idx_d;
    logic             timeout_q, timeout_d;

    logic [13:0]      req_dbl;
    logic [6:0]       req_rot;
    logic [2:0]       off;
    logic [3:0]       sum;
    logic [2:0]       win;
    logic             any_req;
    logic             at_limit;
    logic             revoke;

    // State register: reset leaves requester 0 as top priority (last = 6).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 3'd6;
            holder_q  <= 3'd0;
            hold_q    <= '0;
            grant_q   <= 7'd0;
            idx_q     <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            holder_q  <= holder_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    // Winner search: rotate requests so the one after 'last' sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl = {bus.req, bus.req};
        req_rot = req_dbl[4'(last_q) + 4'd1 +: 7];
        off     = 3'd0;
        for (int j = 6; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = 3'(j);
            end
        end
        sum     = 4'(last_q) + 4'd1 + 4'(off);
        win     = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
        any_req = |bus.req;
    end

    // Next-state logic: grant from IDLE, hold or revoke in GRANT; release beats timeout.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        holder_d  = holder_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        at_limit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        revoke    = bus.rel || !bus.req[holder_q] || at_limit;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = GRANT;
                    holder_d = win;
                    hold_d   = '0;
                    grant_d  = 7'd1 << win;
                    idx_d    = win + 3'd1;
                end
            end
            GRANT: begin
                if (revoke) begin
                    state_d   = IDLE;
                    last_d    = holder_q;
                    hold_d    = '0;
                    grant_d   = 7'd0;
                    idx_d     = 3'd0;
                    timeout_d = at_limit && !bus.rel && bus.req[holder_q];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 7'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Outputs come straight from registers; busy tracks the GRANT state.
    always_comb begin
        bus.grant     = grant_q;
        bus.grant_idx = idx_q;
        bus.busy      = (state_q == GRANT);
        bus.timeout   = timeout_q;
    end

endmodule

// File: tb/tb_rr_arbiter7.sv
// Directed scoreboard bench for rr_arbiter7 built with MAX_HOLD = 4.
module tb_rr_arbiter7;

    typedef struct {
        string      tag;
        logic [2:0] idx;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    rr_arbiter7_if bus ();

    rr_arbiter7 #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [6:0]  eg;
        logic [11:0] want;
        logic [11:0] obs;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed no expectation, required one");
            return;
        end
        e    = sb.pop_front();
        eg   = (e.idx == 3'd0) ? 7'd0 : (7'd1 << (e.idx - 3'd1));
        want = {eg, e.idx, (e.idx != 3'd0), e.to};
        obs  = {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
        assert (obs === want) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed grant=%b idx=%0d busy=%b timeout=%b, required grant=%b idx=%0d busy=%b timeout=%b",
                   e.tag, obs[11:5], obs[4:2], obs[1], obs[0], want[11:5], want[4:2], want[1], want[0]);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
    task automatic applyStimulus(input logic r, input logic [6:0] rq, input logic rl,
                                 input logic [2:0] e_idx, input logic e_to, input string tag);
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.rel = rl;
        sb.push_back('{tag, e_idx, e_to});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Directed sequence covering reset, single requester, rotation, wrap, timeout and drops.
    initial begin
        bus.req = 7'd0;
        bus.rel = 1'b0;
        $display("[TB] starting rr_arbiter7 directed run");

        applyStimulus(1'b1, 7'h00, 1'b0, 3'd0, 1'b0, "reset_0");
        applyStimulus(1'b1, 7'h00, 1'b0, 3'd0, 1'b0, "reset_1");

        // Single requester 2, released in its third grant cycle, then re-granted.
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "single_grant_c1");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "single_grant_c2");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "single_grant_c3");
        applyStimulus(1'b0, 7'h04, 1'b1, 3'd0, 1'b0, "single_release");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "single_regrant");
        applyStimulus(1'b0, 7'h04, 1'b1, 3'd0, 1'b0, "single_release2");

        // Full rotation from a fresh reset.
        applyStimulus(1'b1, 7'h00, 1'b0, 3'd0, 1'b0, "rot_reset");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 7'h7f, 1'b0, 3'((k % 7) + 1), 1'b0, $sformatf("rot_grant_%0d", k));
            applyStimulus(1'b0, 7'h7f, 1'b1, 3'd0, 1'b0, $sformatf("rot_gap_%0d", k));
        end

        // Wrap-around fairness after requester 5 held last.
        applyStimulus(1'b0, 7'h20, 1'b0, 3'd6, 1'b0, "wrap_setup");
        applyStimulus(1'b0, 7'h20, 1'b1, 3'd0, 1'b0, "wrap_setup_rel");
        applyStimulus(1'b0, 7'h43, 1'b0, 3'd7, 1'b0, "wrap_first");
        applyStimulus(1'b0, 7'h43, 1'b1, 3'd0, 1'b0, "wrap_gap1");
        applyStimulus(1'b0, 7'h43, 1'b0, 3'd1, 1'b0, "wrap_second");
        applyStimulus(1'b0, 7'h43, 1'b1, 3'd0, 1'b0, "wrap_gap2");
        applyStimulus(1'b0, 7'h43, 1'b0, 3'd2, 1'b0, "wrap_third");
        applyStimulus(1'b0, 7'h43, 1'b1, 3'd0, 1'b0, "wrap_gap3");

        // Release while idle has no effect.
        applyStimulus(1'b0, 7'h00, 1'b1, 3'd0, 1'b0, "idle_release");

        // Timeout: requester 4 held without release for exactly four cycles.
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "to_hold_1");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "to_hold_2");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "to_hold_3");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "to_hold_4");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd0, 1'b1, "to_pulse");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "to_regrant");

        // Release in the fourth held cycle wins over the timeout.
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "reltot_hold_2");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "reltot_hold_3");
        applyStimulus(1'b0, 7'h10, 1'b0, 3'd5, 1'b0, "reltot_hold_4");
        applyStimulus(1'b0, 7'h10, 1'b1, 3'd0, 1'b0, "reltot_drop");

        // Mid-grant reset must restore requester 0 as top priority.
        applyStimulus(1'b0, 7'h01, 1'b0, 3'd1, 1'b0, "rst_pre_grant0");
        applyStimulus(1'b0, 7'h01, 1'b1, 3'd0, 1'b0, "rst_pre_rel0");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "rst_grant2_c1");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "rst_grant2_c2");
        applyStimulus(1'b1, 7'h04, 1'b1, 3'd0, 1'b0, "rst_mid_grant");
        applyStimulus(1'b0, 7'h05, 1'b0, 3'd1, 1'b0, "rst_then_req0");
        applyStimulus(1'b0, 7'h05, 1'b1, 3'd0, 1'b0, "rst_then_rel");

        // Holder drops its request: plain revoke, no timeout pulse.
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "drop_grant");
        applyStimulus(1'b0, 7'h00, 1'b0, 3'd0, 1'b0, "drop_revoke");

        // Holder drops its request exactly at the hold limit: still no timeout pulse.
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "droplim_1");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "droplim_2");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "droplim_3");
        applyStimulus(1'b0, 7'h04, 1'b0, 3'd3, 1'b0, "droplim_4");
        applyStimulus(1'b0, 7'h00, 1'b0, 3'd0, 1'b0, "droplim_revoke");
        applyStimulus(1'b0, 7'h00, 1'b0, 3'd0, 1'b0, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter7.md
Name: rr_arbiter7

Overview:
- Round-robin arbiter that shares one resource among 7 requesters.
- Issues a registered one-hot grant and its 3-bit encoded index. The index uses the same code as the team's 7-to-3 encoder: bit k maps to k+1, and no grant maps to 0.
- Supports an optional maximum-hold timeout so one requester cannot starve the others.
- Sits between the request sources and the shared datapath. Downstream steering logic uses grant_idx as its select.

Parameters:
- MAX_HOLD, 15: maximum consecutive cycles a grant may be held. 0 disables the timeout.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  7  request vector; bit k = requester k
- release  input  1  holder finished; sampled only in GRANT
- grant  output  7  one-hot grant, registered
- grant_idx  output  3  encoded grant: 0 = none, k+1 = requester k
- busy  output  1  high while in GRANT
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset values: grant=0, grant_idx=0, busy=0, timeout=0, state=IDLE, last=6, hold_cnt=0.
- Setting last=6 at reset makes requester 0 the highest priority after reset.
- States: IDLE and GRANT.
- IDLE, req==0: stay in IDLE; outputs remain 0.
- IDLE, req!=0: pick the winner w as the first set bit in search order last+1, last+2, ..., last+6, last, all mod 7.
  - Next cycle: grant=1<<w, grant_idx=w+1, busy=1, hold_cnt=0, state=GRANT.
  - Latency is one cycle from req sampled to grant visible.
- GRANT, holder g. Revocation occurs when any of these is true:
  - release==1;
  - req[g]==0;
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- GRANT, no revocation: hold_cnt increments; grant is unchanged.
- GRANT, revocation: next cycle grant=0, grant_idx=0, busy=0, last=g, hold_cnt=0, state=IDLE.
  - timeout=1 for exactly that cycle only if the timeout condition caused the revocation and release==0 and req[g]==1.
  - Otherwise timeout=0.
- Grant duration with no release is exactly MAX_HOLD cycles.
- There is always one idle turnaround cycle between consecutive grants, including a re-grant to the same requester.
- Simultaneous events: when release and the timeout condition are true in the same cycle, release wins and timeout stays 0.
- Requests from non-holders during GRANT are ignored until the next IDLE cycle. Requests are not latched; a requester must hold req high.
- A sole requester may be re-granted after the turnaround cycle. Fairness applies only when there is competition.
- release while in IDLE is ignored.
- Invariants, every cycle:
  - grant has at most one bit set;
  - grant_idx equals the encoding of grant;
  - busy equals (grant!=0).
- rst asserted mid-GRANT: on the next edge all outputs return to their reset values and last=6, regardless of req or release.

Test Plan:
- Reset then single requester: rst=1 for 2 cycles, then req=7'b0000100 held, release at the 3rd grant cycle.
  - Expect grant=7'b0000100 and grant_idx=3 one cycle after req.
  - Grant held 3 cycles, then 0 for one cycle, then re-granted.
- Rotation: req=7'b1111111 held; release pulsed every grant.
  - Expect grant_idx sequence 1,2,3,4,5,6,7,1 with a 0 between each.
  - grant is always one-hot matching grant_idx.
- Fairness with wrap: last=5 after granting requester 5; req=7'b1000011.
  - Expect grant_idx=7, then 1, then 2.
- Timeout: MAX_HOLD=4, req=7'b0010000 held, no release.
  - Expect grant_idx=5 for exactly 4 cycles, then timeout=1 with grant=0 for one cycle.
  - Then re-grant to requester 4.
- Release and timeout together: MAX_HOLD=4, release=1 in the 4th held cycle.
  - Expect grant dropped next cycle with timeout=0.
- Mid-grant reset and req drop:
  - During a grant to requester 2, assert rst: expect all outputs 0 next cycle, then requester 0 wins first when req=7'b0000101.
  - Separately, drop req[2] while granted: expect grant=0 next cycle with timeout=0.
